// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package rv_fetch_pkg;

  localparam int              PC_W             = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSN         = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of fetch entries.
// Flush beats push and pop; the head reads as all-zero while the queue is empty.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL  = LVL_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != FULL) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Entry storage needs no reset: the head is masked while level is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign level = level_q;

endmodule

// File: rtl/rv_fetch_unit.sv
// Fetch-PC sequencer: issues word requests, tracks the single inflight response and feeds the prefetch queue.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirects enqueue a trap entry and halt fetch.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [31:0]            if_insn,
  output logic [XLEN-1:0]        if_pc,
  output logic                   if_trap,
  output logic [$clog2(DEPTH):0] level
);

  localparam int             LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W:0] CAP   = (LVL_W + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            halted, trap_pend;
  logic            pop, push;
  logic [LVL_W:0]  occupancy;
  fetch_entry_t    push_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;
  logic trap_pend_q, trap_pend_d;
  assign halted    = halted_q;
  assign trap_pend = trap_pend_q;
`else
  assign halted    = 1'b0;
  assign trap_pend = 1'b0;
`endif

  assign if_valid  = (level != '0);
  assign pop       = if_valid && if_ready;
  // Slots already promised: current entries, minus the one leaving, plus the response on its way.
  assign occupancy = {1'b0, level} - (LVL_W + 1)'(pop) + (LVL_W + 1)'(inflight_q);
  assign imem_req  = !reset && !redirect_valid && !halted && (occupancy < CAP);
  assign imem_addr = fetch_pc_q[ADDR_W+1:2];

  // Fetch PC, inflight tracking and halt state; a redirect leaves nothing inflight, killing any stale response.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    halted_d      = halted_q;
    trap_pend_d   = 1'b0;
`endif
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_pc_d  = redirect_pc;
      halted_d    = (redirect_pc[1:0] != 2'b00);
      trap_pend_d = (redirect_pc[1:0] != 2'b00);
`else
      fetch_pc_d  = redirect_pc & ~XLEN'(2'b11);
`endif
    end else if (imem_req) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Queue push source: a pending trap entry, else a live memory response.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (trap_pend) begin
      push            = 1'b1;
      push_entry.pc   = PC_W'(fetch_pc_q);
      push_entry.insn = 32'h0000_0000;
      push_entry.trap = 1'b1;
    end else if (imem_rvalid && inflight_q) begin
      push            = 1'b1;
      push_entry.pc   = PC_W'(inflight_pc_q);
      push_entry.insn = imem_rdata;
      push_entry.trap = 1'b0;
    end else begin
      push = 1'b0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Halt flag and one-shot trap enqueue request.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q    <= 1'b0;
      trap_pend_q <= 1'b0;
    end else begin
      halted_q    <= halted_d;
      trap_pend_q <= trap_pend_d;
    end
  end
`endif

  rv_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .level     (level)
  );

  assign if_insn = head.insn;
  assign if_pc   = XLEN'(head.pc);
  assign if_trap = head.trap;

endmodule
